capture_ctrl: RTL and testbench

- Downstream consumer of the trigger unit.
- Writes sample words into an external ring-buffer RAM while armed, then waits for the trigger's run flag and captures a programmed number of post-trigger samples.
- Finally reads the buffer back, newest sample first, as a valid/ready word stream toward the transmitter.
- Count fields follow the SUMP "set read & delay count" command.

---
 rtl/logIP_pkg.sv | 28 ++
 rtl/capture_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_capture_ctrl.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/logIP_pkg.sv
// +----------------------------------------------------------------------+
// | logIP_pkg: shared types and constants for the logIP capture path      |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

package logIP_pkg;

  localparam int CNT_W = 18;
  localparam logic [7:0] SUMP_SET_CNT = 8'h81;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARMED   = 3'd1,
    DELAY   = 3'd2,
    RD_ADDR = 3'd3,
    RD_DATA = 3'd4,
    SEND    = 3'd5
  } capture_state_t;

  // One bit wider than CNT_W so that a field of 0xFFFF (2**18) is exact.
  function automatic logic [CNT_W:0] cnt_from_field(input logic [15:0] f);
    cnt_from_field = {1'b0, f, 2'b00} + (CNT_W + 1)'(4);
  endfunction

endpackage

`default_nettype wire

// File: rtl/capture_ctrl.sv
// +----------------------------------------------------------------------+
// | capture_ctrl: ring-buffer sample capture with post-trigger delay and  |
// | newest-first valid/ready readout. Optional macro:                     |
// | LOGIP_CAPTURE_ABORT_EN adds abort_i.                                  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module capture_ctrl
  import logIP_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
`ifdef LOGIP_CAPTURE_ABORT_EN
  input  logic              abort_i,
`endif
  input  logic [31:0]       cmd_i,
  input  logic              set_cnt_i,
  input  logic              exec_i,
  input  logic              arm_i,
  input  logic              run_i,
  input  logic              stb_i,
  input  logic [DATA_W-1:0] smpls_i,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic [DATA_W-1:0] tx_data_o,
  output logic              tx_valid_o,
  input  logic              tx_ready_i,
  output logic              busy_o
);

  localparam logic [CNT_W:0]   DEPTH   = (CNT_W + 1)'(1) << ADDR_W;
  localparam logic [CNT_W-1:0] RST_CNT = CNT_W'(4);

  capture_state_t    state_q, state_d;
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic [CNT_W-1:0]  dcnt_q, dcnt_d;
  logic [CNT_W-1:0]  rcnt_q, rcnt_d;
  logic [CNT_W-1:0]  delay_n_q, delay_n_d;
  logic [CNT_W-1:0]  read_n_q, read_n_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic              tx_valid_q, tx_valid_d;

  logic              w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic [CNT_W-1:0]  w_delay_n;
  logic [CNT_W:0]    w_read_full;
  logic [CNT_W-1:0]  w_read_n;

  // A delay field of 0xFFFF wraps to 0; counting down through the wrap
  // still yields exactly 2**18 writes before the counter returns to 0.
  assign w_delay_n   = {cmd_i[31:16], 2'b00} + CNT_W'(4);
  assign w_read_full = cnt_from_field(cmd_i[15:0]);
  assign w_read_n    = (w_read_full > DEPTH) ? DEPTH[CNT_W-1:0] : w_read_full[CNT_W-1:0];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      wptr_q     <= '0;
      raddr_q    <= '0;
      dcnt_q     <= '0;
      rcnt_q     <= '0;
      delay_n_q  <= RST_CNT;
      read_n_q   <= RST_CNT;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      raddr_q    <= raddr_d;
      dcnt_q     <= dcnt_d;
      rcnt_q     <= rcnt_d;
      delay_n_q  <= delay_n_d;
      read_n_q   <= read_n_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wptr_d     = wptr_q;
    raddr_d    = raddr_q;
    dcnt_d     = dcnt_q;
    rcnt_d     = rcnt_q;
    delay_n_d  = delay_n_q;
    read_n_d   = read_n_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    w_we       = 1'b0;
    w_addr     = '0;
    w_wdata    = '0;

    if (exec_i && set_cnt_i) begin
      delay_n_d = w_delay_n;
      read_n_d  = w_read_n;
    end

    case (state_q)
      IDLE: begin
        if (arm_i) begin
          state_d = ARMED;
          dcnt_d  = delay_n_q;
          rcnt_d  = read_n_q;
        end
      end

      ARMED: begin
        w_addr = wptr_q;
        if (stb_i) begin
          w_we    = 1'b1;
          w_wdata = smpls_i;
          wptr_d  = wptr_q + ADDR_W'(1);
        end
        if (arm_i) begin
          dcnt_d = delay_n_q;
          rcnt_d = read_n_q;
        end else if (run_i) begin
          // A sample coinciding with the trigger is the first delay sample.
          if (stb_i && dcnt_q == CNT_W'(1)) begin
            state_d = RD_ADDR;
            raddr_d = wptr_q;
          end else begin
            state_d = DELAY;
          end
          dcnt_d = dcnt_q - CNT_W'(stb_i);
        end
      end

      DELAY: begin
        w_addr = wptr_q;
        if (stb_i) begin
          w_we    = 1'b1;
          w_wdata = smpls_i;
          wptr_d  = wptr_q + ADDR_W'(1);
        end
        if (arm_i) begin
          state_d = ARMED;
          dcnt_d  = delay_n_q;
          rcnt_d  = read_n_q;
        end else if (stb_i) begin
          dcnt_d = dcnt_q - CNT_W'(1);
          if (dcnt_q == CNT_W'(1)) begin
            state_d = RD_ADDR;
            raddr_d = wptr_q;
          end
        end
      end

      RD_ADDR: begin
        w_addr  = raddr_q;
        state_d = RD_DATA;
      end

      RD_DATA: begin
        w_addr     = raddr_q;
        tx_data_d  = mem_rdata_i;
        tx_valid_d = 1'b1;
        state_d    = SEND;
      end

      SEND: begin
        w_addr = raddr_q;
        if (tx_ready_i) begin
          tx_valid_d = 1'b0;
          rcnt_d     = rcnt_q - CNT_W'(1);
          raddr_d    = raddr_q - ADDR_W'(1);
          state_d    = (rcnt_q == CNT_W'(1)) ? IDLE : RD_ADDR;
        end
      end

      default: state_d = IDLE;
    endcase

`ifdef LOGIP_CAPTURE_ABORT_EN
    if (abort_i) begin
      state_d    = IDLE;
      tx_valid_d = 1'b0;
      w_we       = 1'b0;
      wptr_d     = wptr_q;
    end
`endif
  end

  assign mem_we_o    = w_we;
  assign mem_addr_o  = w_addr;
  assign mem_wdata_o = w_wdata;
  assign tx_data_o   = tx_data_q;
  assign tx_valid_o  = tx_valid_q;
  assign busy_o      = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_capture_ctrl.sv
// +----------------------------------------------------------------------+
// | tb_capture_ctrl: directed vector bench for capture_ctrl (ADDR_W=4)    |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_capture_ctrl;

  localparam int AW = 4;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          abort_i = 1'b0;
  logic [31:0]   cmd_i = '0;
  logic          set_cnt_i = 1'b0;
  logic          exec_i = 1'b0;
  logic          arm_i = 1'b0;
  logic          run_i = 1'b0;
  logic          stb_i = 1'b0;
  logic [DW-1:0] smpls_i = '0;
  logic          mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic [DW-1:0] mem_rdata_i;
  logic [DW-1:0] tx_data_o;
  logic          tx_valid_o;
  logic          tx_ready_i = 1'b0;
  logic          busy_o;

  always #5 clk = ~clk;

  capture_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
`ifdef LOGIP_CAPTURE_ABORT_EN
    .abort_i    (abort_i),
`endif
    .cmd_i      (cmd_i),
    .set_cnt_i  (set_cnt_i),
    .exec_i     (exec_i),
    .arm_i      (arm_i),
    .run_i      (run_i),
    .stb_i      (stb_i),
    .smpls_i    (smpls_i),
    .mem_we_o   (mem_we_o),
    .mem_addr_o (mem_addr_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i),
    .tx_data_o  (tx_data_o),
    .tx_valid_o (tx_valid_o),
    .tx_ready_i (tx_ready_i),
    .busy_o     (busy_o)
  );

  // Parent-side RAM: synchronous write, one-cycle read latency.
  logic [DW-1:0] ram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_we_o) ram[mem_addr_o] <= mem_wdata_o;
    mem_rdata_i <= ram[mem_addr_o];
  end

  typedef struct {
    logic [31:0] cmd;
    bit          prog;
    int          pre;
    int          post;
    int          words;
    int          stall;
    bit          arm_rd;
  } vec_t;

  vec_t          vecs [6];
  int            n_chk  = 0;
  int            n_fail = 0;
  logic [AW-1:0] wp     = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic write_phase(input vec_t v, input int id);
    int   total;
    logic exp_we;
    if (v.prog) begin
      exec_i = 1'b1; set_cnt_i = 1'b1; cmd_i = v.cmd;
      cyc();
      exec_i = 1'b0; set_cnt_i = 1'b0; cmd_i = '0;
    end
    // Trigger while idle must not start anything.
    run_i = 1'b1; stb_i = 1'b1; smpls_i = '1;
    #1;
    check("idle_run_we", {31'd0, mem_we_o}, 32'd0);
    check("idle_busy", {31'd0, busy_o}, 32'd0);
    cyc();
    run_i = 1'b0; stb_i = 1'b0;
    arm_i = 1'b1;
    cyc();
    arm_i = 1'b0;
    #1;
    check("armed_busy", {31'd0, busy_o}, 32'd1);
    total = v.pre + v.post + 3;
    for (int i = 0; i < total; i++) begin
      if (i > v.pre && i[0]) begin
        stb_i = 1'b0; run_i = 1'b0; arm_i = 1'b0;
        #1;
        check("gap_we", {31'd0, mem_we_o}, 32'd0);
        cyc();
      end
      stb_i   = 1'b1;
      smpls_i = DW'(id * 1000 + i);
      run_i   = (i == v.pre);
      arm_i   = v.arm_rd && (i >= v.pre + v.post);
      #1;
      exp_we = (i < v.pre + v.post);
      check("wr_en", {31'd0, mem_we_o}, {31'd0, exp_we});
      if (exp_we) begin
        check("wr_addr", {28'd0, mem_addr_o}, {28'd0, wp});
        check("wr_data", mem_wdata_o, 32'(id * 1000 + i));
        wp = wp + 1'b1;
      end
      cyc();
    end
    stb_i = 1'b0; run_i = 1'b0; arm_i = 1'b0;
  endtask

  task automatic readout(input vec_t v, input int id);
    int          k;
    int          stall_left;
    int          budget;
    logic [31:0] exp;
    logic [31:0] last;
    k = 0; stall_left = 5; budget = v.words * 4 + 20;
    last = 32'(id * 1000 + v.pre + v.post - 1);
    while (k < v.words && budget > 0) begin
      exp = last - 32'(k);
      if (tx_valid_o && k == v.stall && stall_left > 0) begin
        tx_ready_i = 1'b0; arm_i = v.arm_rd; stall_left--;
        #1;
        check("stall_valid", {31'd0, tx_valid_o}, 32'd1);
        check("stall_data", tx_data_o, exp);
      end else begin
        tx_ready_i = 1'b1; arm_i = 1'b0;
        #1;
        if (tx_valid_o) begin
          check("rd_data", tx_data_o, exp);
          k++;
        end
      end
      cyc();
      budget--;
    end
    tx_ready_i = 1'b0; arm_i = 1'b0;
    check("rd_count", 32'(k), 32'(v.words));
    #1;
    check("end_busy", {31'd0, busy_o}, 32'd0);
    check("end_valid", {31'd0, tx_valid_o}, 32'd0);
  endtask

  initial begin
    vec_t r;
    vecs[0] = '{cmd: 32'h0000_0001, prog: 1'b1, pre: 20, post: 4,  words: 8,  stall: -1, arm_rd: 1'b0};
    vecs[1] = '{cmd: 32'h0000_0001, prog: 1'b1, pre: 20, post: 4,  words: 8,  stall: 1,  arm_rd: 1'b1};
    vecs[2] = '{cmd: 32'h0000_FFFF, prog: 1'b1, pre: 30, post: 4,  words: 16, stall: -1, arm_rd: 1'b0};
    vecs[3] = '{cmd: 32'h0001_0000, prog: 1'b1, pre: 5,  post: 8,  words: 4,  stall: 0,  arm_rd: 1'b0};
    vecs[4] = '{cmd: 32'h0002_0002, prog: 1'b1, pre: 3,  post: 12, words: 12, stall: -1, arm_rd: 1'b0};
    vecs[5] = '{cmd: 32'h0000_0000, prog: 1'b1, pre: 0,  post: 4,  words: 4,  stall: -1, arm_rd: 1'b0};

    rst_i = 1'b1;
    cyc(); cyc();
    rst_i = 1'b0;
    #1;
    check("rst_we", {31'd0, mem_we_o}, 32'd0);
    check("rst_addr", {28'd0, mem_addr_o}, 32'd0);
    check("rst_wdata", mem_wdata_o, 32'd0);
    check("rst_txdata", tx_data_o, 32'd0);
    check("rst_valid", {31'd0, tx_valid_o}, 32'd0);
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    cyc();

    for (int s = 0; s < 6; s++) begin
      write_phase(vecs[s], s);
      readout(vecs[s], s);
      cyc();
    end

`ifdef LOGIP_CAPTURE_ABORT_EN
    exec_i = 1'b1; set_cnt_i = 1'b1; cmd_i = 32'h0001_0000;
    cyc();
    exec_i = 1'b0; set_cnt_i = 1'b0; cmd_i = '0;
    arm_i = 1'b1;
    cyc();
    arm_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      stb_i = 1'b1; smpls_i = DW'(9000 + i); run_i = (i == 3);
      #1;
      check("ab_wr_en", {31'd0, mem_we_o}, 32'd1);
      wp = wp + 1'b1;
      cyc();
    end
    run_i = 1'b0;
    abort_i = 1'b1;
    #1;
    check("ab_same_we", {31'd0, mem_we_o}, 32'd0);
    cyc();
    abort_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      stb_i = 1'b1; smpls_i = DW'(9100 + i);
      #1;
      check("ab_busy", {31'd0, busy_o}, 32'd0);
      check("ab_we", {31'd0, mem_we_o}, 32'd0);
      check("ab_valid", {31'd0, tx_valid_o}, 32'd0);
      cyc();
    end
    stb_i = 1'b0;
`endif

    // Reset while a word is waiting in SEND, then re-arm on reset counts.
    r = '{cmd: 32'h0002_0002, prog: 1'b1, pre: 2, post: 12, words: 12, stall: -1, arm_rd: 1'b0};
    write_phase(r, 10);
    #1;
    check("pre_rst_valid", {31'd0, tx_valid_o}, 32'd1);
    rst_i = 1'b1;
    cyc();
    rst_i = 1'b0;
    #1;
    check("mid_rst_valid", {31'd0, tx_valid_o}, 32'd0);
    check("mid_rst_busy", {31'd0, busy_o}, 32'd0);
    check("mid_rst_we", {31'd0, mem_we_o}, 32'd0);
    check("mid_rst_txdata", tx_data_o, 32'd0);
    wp = '0;
    r = '{cmd: 32'h0000_0000, prog: 1'b0, pre: 2, post: 4, words: 4, stall: -1, arm_rd: 1'b0};
    write_phase(r, 11);
    readout(r, 11);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete, got running, expected finished");
    $fatal(1);
  end

endmodule

`default_nettype wire
